// File: rtl/saratoga_pkg.sv
// Shared types for the data-memory port and its alignment helper.
//  mem_size_t      : access width of a load/store (2'b11 is not a legal size)
//  dmem_rsp_ctx_t  : per-request context carried from accept into the response stage
package saratoga_pkg;

  localparam int DEFAULT_RAM_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic [1:0] off;
    mem_size_t  size;
    logic       is_unsigned;
    logic       we;
    logic       fault;
  } dmem_rsp_ctx_t;

  // Natural alignment for the given size; the illegal size never aligns.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_BYTE: is_aligned = 1'b1;
      MEM_HALF: is_aligned = (off[0] == 1'b0);
      MEM_WORD: is_aligned = (off == 2'b00);
      default:  is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane select and sign/zero extension of a 32-bit ram word.
// Shared with the instruction-fetch path.
//  word        in   32  raw ram word
//  off         in   2   byte offset within the word
//  size        in   2   mem_size_t of the access
//  is_unsigned in   1   zero-extend (1) or sign-extend (0)
//  data        out  32  right-justified, extended result
module dmem_align
  import saratoga_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign shifted = word >> {off, 3'b000};
  assign lane_b  = shifted[7:0];
  // Halves are only ever at offset 0 or 2, so off[1] picks the half.
  assign lane_h  = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (size)
      MEM_BYTE: data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      MEM_HALF: data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/dmem_port.sv
// Byte-addressed load/store front end for the word-addressed, byte-strobed ram.
//  clk, rst                    clock, synchronous active-high reset
//  req_valid/ready, req_*      request channel (byte address, store flag, size, sign, data)
//  rsp_valid/ready, rsp_*      response channel (aligned load data, access fault)
//  ram_*                       ram drive (word address, strobes, replicated data); rd_data
//                              returns one cycle after ram_rd_en
module dmem_port
  import saratoga_pkg::*;
#(
  parameter int          ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic                  ram_rd_en,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wr_data,
  output logic [3:0]            ram_wr_strobe,
  input  logic [31:0]           ram_rd_data
);

  // 33 bits so a 4 GiB window does not overflow.
  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_WIDTH;

  logic          accept, in_range, aligned, ok;
  logic [31:0]   rel_addr;
  logic [1:0]    off;
  mem_size_t     size;
  dmem_rsp_ctx_t ctx;
  logic [31:0]   aligned_rdata;

  assign off       = req_addr[1:0];
  assign size      = mem_size_t'(req_size);
  assign rel_addr  = req_addr - BASE_ADDR;
  assign in_range  = {1'b0, rel_addr} < WIN_BYTES;
  assign aligned   = is_aligned(req_size, off);
  assign ok        = in_range & aligned;

  // The response stage doubles as the only buffer: stall requests while it is held.
  assign req_ready = !rsp_valid | rsp_ready;
  // Nothing is accepted in the reset cycle, which keeps a store there off the ram.
  assign accept    = req_valid & req_ready & !rst;

  assign ram_rd_en = accept & !req_we & ok;
  assign ram_wr_en = accept &  req_we & ok;
  assign ram_addr  = req_addr[ADDR_WIDTH+1:2];

  always_comb begin
    ram_wr_strobe = 4'b0000;
    ram_wr_data   = req_wdata;
    case (size)
      MEM_BYTE: begin
        ram_wr_strobe = 4'b0001 << off;
        ram_wr_data   = {4{req_wdata[7:0]}};
      end
      MEM_HALF: begin
        ram_wr_strobe = 4'b0011 << off;
        ram_wr_data   = {2{req_wdata[15:0]}};
      end
      MEM_WORD: begin
        ram_wr_strobe = 4'b1111;
        ram_wr_data   = req_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      ctx       <= '0;
    end else if (req_ready) begin
      rsp_valid <= accept;
      if (accept) begin
        ctx.off         <= off;
        ctx.size        <= size;
        ctx.is_unsigned <= req_unsigned;
        ctx.we          <= req_we;
        ctx.fault       <= !ok;
      end
    end
  end

  // ram holds rd_data while stalled (no rd_en), so this stays stable without a buffer.
  dmem_align u_align (
    .word        (ram_rd_data),
    .off         (ctx.off),
    .size        (ctx.size),
    .is_unsigned (ctx.is_unsigned),
    .data        (aligned_rdata)
  );

  assign rsp_rdata = (rsp_valid && !ctx.we && !ctx.fault) ? aligned_rdata : 32'h0;
  assign rsp_fault = rsp_valid & ctx.fault;

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;
  import saratoga_pkg::*;

  localparam int AW = 6;  // 256-byte window at base 0

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_size;
  logic          rsp_valid, rsp_ready, rsp_fault;
  logic [31:0]   rsp_rdata;
  logic          ram_rd_en, ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wr_data, ram_rd_data;
  logic [3:0]    ram_wr_strobe;

  always #5 clk = ~clk;

  dmem_port #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_wr_strobe(ram_wr_strobe), .ram_rd_data(ram_rd_data)
  );

  // ram model: write then read, 1-cycle read latency, rd_data held when idle
  logic [31:0] mem [2**AW];
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'h0;
    ram_rd_data = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_wr_en)
      for (int b = 0; b < 4; b++)
        if (ram_wr_strobe[b]) mem[ram_addr][b*8 +: 8] = ram_wr_data[b*8 +: 8];
    if (ram_rd_en) ram_rd_data <= mem[ram_addr];
  end

  // byte-level reference image, updated as stores are accepted
  logic [7:0] ref_mem [256];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;

  typedef struct { logic [31:0] rdata; logic fault; } exp_t;
  exp_t exp_q[$];
  int   rsp_cyc[$];
  int   checks = 0, errors = 0, cyc = 0, stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // response monitor / scoreboard pop
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
          rsp_cyc.push_back(cyc);
        end
      end else begin
        stall_cnt++;
        check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        if (exp_q.size() != 0) check("stall_rdata", rsp_rdata, exp_q[0].rdata);
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] w;
    logic [31:0] r;
    w = {ref_mem[{a[7:2], 2'd3}], ref_mem[{a[7:2], 2'd2}], ref_mem[{a[7:2], 2'd1}], ref_mem[{a[7:2], 2'd0}]};
    case (sz)
      2'd0: begin r = {24'd0, ref_mem[a[7:0]]}; if (!u && r[7]) r[31:8] = '1; end
      2'd1: begin r = {16'd0, ref_mem[a[7:0] + 8'd1], ref_mem[a[7:0]]}; if (!u && r[15]) r[31:16] = '1; end
      default: r = w;
    endcase
    return r;
  endfunction

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rdata, input logic exp_fault);
    logic rdy;
    int   n = 0;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    do begin
      @(negedge clk);
      rdy = req_ready;
      if (rdy) begin
        check("ram_rd_en", {31'd0, ram_rd_en}, {31'd0, !we && !exp_fault});
        check("ram_wr_en", {31'd0, ram_wr_en}, {31'd0, we && !exp_fault});
        if (!exp_fault) check("ram_addr", {26'd0, ram_addr}, {26'd0, a[7:2]});
        if (we && !exp_fault) begin
          check("ram_wr_strobe", {28'd0, ram_wr_strobe}, {28'd0, exp_strb});
          check("ram_wr_data", ram_wr_data, exp_wd);
        end
      end else check("ram_en_while_stalled", {30'd0, ram_rd_en, ram_wr_en}, 32'd0);
      @(posedge clk); #1; n++;
    end while (!rdy && n < 50);
    if (!rdy) check("accept_timeout", 32'd0, 32'd1);
    if (rdy && we && !exp_fault)
      for (int b = 0; b < 4; b++)
        if (exp_strb[b]) ref_mem[{a[7:2], 2'(b)}] = exp_wd[b*8 +: 8];
    e.rdata = exp_rdata; e.fault = exp_fault;
    exp_q.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a,
                    input logic [31:0] exp_rdata, input logic exp_fault);
    issue(1'b0, sz, u, a, 32'h0, 4'h0, 32'h0, exp_rdata, exp_fault);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_fault", {31'd0, rsp_fault}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // word store, then narrow loads out of it
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    ld(2'd0, 1'b0, 32'h13, 32'hFFFFFFDE, 1'b0);
    ld(2'd0, 1'b1, 32'h13, 32'h000000DE, 1'b0);
    ld(2'd1, 1'b0, 32'h12, 32'hFFFFDEAD, 1'b0);
    ld(2'd1, 1'b1, 32'h10, 32'h0000BEEF, 1'b0);
    ld(2'd0, 1'b0, 32'h11, 32'hFFFFFFBE, 1'b0);
    ld(2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

    // byte store merges into a word
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 4'b1111, 32'h11223344, 32'h0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0);
    ld(2'd2, 1'b0, 32'h20, 32'h1122A544, 1'b0);

    // misaligned / illegal size / out-of-range faults
    ld(2'd2, 1'b0, 32'h02, 32'h0, 1'b1);
    ld(2'd1, 1'b0, 32'h01, 32'h0, 1'b1);
    ld(2'd3, 1'b0, 32'h00, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h22, 32'h55555555, 4'h0, 32'h0, 32'h0, 1'b1);
    ld(2'd2, 1'b0, 32'h100, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'hFC, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0);
    ld(2'd2, 1'b0, 32'hFC, 32'hCAFEF00D, 1'b0);
    ld(2'd2, 1'b0, 32'h20, 32'h1122A544, 1'b0);

    // half store immediately followed by a load of the same word
    issue(1'b1, 2'd1, 1'b0, 32'h32, 32'hABCD7777, 4'b1100, 32'h77777777, 32'h0, 1'b0);
    ld(2'd2, 1'b0, 32'h30, 32'h77770000, 1'b0);
    drain();

    // fill, then 8 back-to-back loads
    for (int i = 0; i < 8; i++)
      issue(1'b1, 2'd2, 1'b0, 32'h40 + 4*i, 32'hA000_0000 + i*32'h0101, 4'b1111,
            32'hA000_0000 + i*32'h0101, 32'h0, 1'b0);
    drain();
    rsp_cyc.delete();
    for (int i = 0; i < 8; i++) ld(2'd2, 1'b0, 32'h40 + 4*i, 32'hA000_0000 + i*32'h0101, 1'b0);
    drain();
    check("burst_rsp_count", rsp_cyc.size(), 32'd8);
    if (rsp_cyc.size() == 8) check("burst_consecutive", rsp_cyc[7] - rsp_cyc[0], 32'd7);

    // same burst with a 3-cycle response stall in the middle
    stall_cnt = 0;
    fork
      begin repeat (3) @(posedge clk); #1; rsp_ready = 1'b0; repeat (3) @(posedge clk); #1; rsp_ready = 1'b1; end
      for (int i = 0; i < 8; i++)
        ld(2'(i % 3), i[0], 32'h40 + 4*i + (i % 3 == 0 ? 3 : 0), ref_load(32'h40 + 4*i + (i % 3 == 0 ? 3 : 0), 2'(i % 3), i[0]), 1'b0);
    join
    drain();
    check("stall_cycles", stall_cnt, 32'd3);

    // reset while a response is pending; store in the reset cycle must not reach ram
    ld(2'd2, 1'b0, 32'h44, 32'hA000_0101, 1'b0);
    rsp_ready = 1'b0; rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h80; req_wdata = 32'h12345678;
    @(negedge clk);
    check("rst_no_wr_en", {31'd0, ram_wr_en}, 32'd0);
    @(posedge clk); #1; rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rst_drops_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    ld(2'd2, 1'b0, 32'h80, 32'h0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
